// File: rtl/qlf_cfg_pkg.sv
// rtl/qlf_cfg_pkg.sv - shared state encoding and default sizes for the config chain loader
package qlf_cfg_pkg;

  localparam int WORD_W_DEF    = 32;
  localparam int CHAIN_LEN_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/qlf_cfg_rb_packer.sv
// rtl/qlf_cfg_rb_packer.sv - packs chain tail bits LSB first into readback words
// Built only when QLF_CFG_READBACK_EN is defined.
module qlf_cfg_rb_packer
  import qlf_cfg_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample,
  input  logic              din,
  input  logic              last,
  input  logic              clear,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int CW = $clog2(WORD_W);

  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] rb_data_q, rb_data_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rb_valid_q, rb_valid_d;

  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (sample) begin
      acc_d[cnt_q] = din;
      // accumulator is zeroed after every emit, so a short final word has zero MSBs
      if (last || (cnt_q == CW'(WORD_W - 1))) begin
        rb_data_d  = acc_d;
        rb_valid_d = 1'b1;
        acc_d      = '0;
        cnt_d      = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;

endmodule

// File: rtl/qlf_cfg_chain_loader.sv
// rtl/qlf_cfg_chain_loader.sv - serialises host config words into a scan chain, LSB first
// Optional readback of the chain tail is enabled by defining QLF_CFG_READBACK_EN.
module qlf_cfg_chain_loader
  import qlf_cfg_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int CHAIN_LEN = CHAIN_LEN_DEF
) (
  input  logic                         clk,
  input  logic                         R,
  input  logic                         start,
  input  logic                         abort,
  input  logic [WORD_W-1:0]            s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic                         cfg_dout,
  output logic                         cfg_en,
  input  logic                         cfg_din,
  output logic [WORD_W-1:0]            rb_data,
  output logic                         rb_valid,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(CHAIN_LEN+1)-1:0] bit_cnt
);

  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int CW = $clog2(WORD_W);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]     wb_q, wb_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              cfg_dout_q, cfg_dout_d;
  logic              cfg_en_q, cfg_en_d;
  logic              s_ready_q, s_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              last_bit;

  assign last_bit = (bit_cnt_q == BW'(CHAIN_LEN - 1));

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    wb_d       = wb_q;
    bit_cnt_d  = bit_cnt_q;
    cfg_dout_d = 1'b0;
    cfg_en_d   = 1'b0;
    done_d     = done_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = LOAD;
          bit_cnt_d = '0;
          done_d    = 1'b0;
        end
      end
      LOAD: begin
        // bit 0 goes straight onto the output flop so it is driven the cycle after acceptance
        if (s_valid && s_ready_q) begin
          state_d    = SHIFT;
          cfg_en_d   = 1'b1;
          cfg_dout_d = s_data[0];
          shreg_d    = s_data >> 1;
          wb_d       = '0;
        end
      end
      SHIFT: begin
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (last_bit) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (wb_q == CW'(WORD_W - 1)) begin
          state_d = LOAD;
        end else begin
          cfg_en_d   = 1'b1;
          cfg_dout_d = shreg_q[0];
          shreg_d    = shreg_q >> 1;
          wb_d       = wb_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d    = IDLE;
      cfg_en_d   = 1'b0;
      cfg_dout_d = 1'b0;
      done_d     = 1'b0;
      bit_cnt_d  = bit_cnt_q;
    end
    s_ready_d = (state_d == LOAD);
    busy_d    = (state_d == LOAD) || (state_d == SHIFT);
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      wb_q       <= '0;
      bit_cnt_q  <= '0;
      cfg_dout_q <= 1'b0;
      cfg_en_q   <= 1'b0;
      s_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      wb_q       <= wb_d;
      bit_cnt_q  <= bit_cnt_d;
      cfg_dout_q <= cfg_dout_d;
      cfg_en_q   <= cfg_en_d;
      s_ready_q  <= s_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign cfg_dout = cfg_dout_q;
  assign cfg_en   = cfg_en_q;
  assign s_ready  = s_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign bit_cnt  = bit_cnt_q;

`ifdef QLF_CFG_READBACK_EN
  qlf_cfg_rb_packer #(
    .WORD_W(WORD_W)
  ) u_rb_packer (
    .clk      (clk),
    .rst_n    (R),
    .sample   (cfg_en_q),
    .din      (cfg_din),
    .last     (last_bit),
    .clear    (abort),
    .rb_data  (rb_data),
    .rb_valid (rb_valid)
  );
`else
  logic unused_cfg_din;
  assign unused_cfg_din = cfg_din;
  assign rb_data        = '0;
  assign rb_valid       = 1'b0;
`endif

endmodule

// File: tb/tb_qlf_cfg_chain_loader.sv
// tb/tb_qlf_cfg_chain_loader.sv - directed table-driven bench for qlf_cfg_chain_loader
// Readback checks follow QLF_CFG_READBACK_EN.
module tb_qlf_cfg_chain_loader;

  localparam int WW = 32;
  localparam int CL = 40;
  localparam int BW = $clog2(CL + 1);

  logic          clk = 1'b0;
  logic          R, start, abort, s_valid, s_ready;
  logic [WW-1:0] s_data, rb_data;
  logic          cfg_dout, cfg_en, cfg_din, rb_valid, busy, done;
  logic [BW-1:0] bit_cnt;

  always #5 clk = ~clk;

  qlf_cfg_chain_loader #(.WORD_W(WW), .CHAIN_LEN(CL)) dut (
    .clk(clk), .R(R), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cfg_dout(cfg_dout), .cfg_en(cfg_en), .cfg_din(cfg_din),
    .rb_data(rb_data), .rb_valid(rb_valid),
    .busy(busy), .done(done), .bit_cnt(bit_cnt)
  );

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    int          stall;
    logic [39:0] exp;
  } vec_t;

  vec_t        vecs[4];
  int          n_pass = 0;
  int          n_total = 0;
  logic [63:0] got;
  int          n_en;
  int          overlap;
  logic [39:0] pat;
  logic [31:0] rb_q[$];
  int          rb_bad;

  // chain model: records bits shifted out and presents the tail bit pattern
  always @(negedge clk) begin
    if (cfg_en) begin
      if (n_en < 64) got[n_en] = cfg_dout;
      cfg_din = (n_en < 40) ? pat[n_en] : 1'b0;
      n_en++;
      if (s_ready) overlap++;
    end
    if (rb_valid) rb_q.push_back(rb_data);
    if (rb_valid || rb_data != '0) rb_bad++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int stall, input string nm);
    int  i;
    logic ok;
    i = 0;
    while (!s_ready && i < 200) begin @(negedge clk); i++; end
    chk({nm, "_ready_timeout"}, 64'(i < 200), 64'd1);
    repeat (stall) @(negedge clk);
    s_data = w; s_valid = 1'b1;
    i = 0;
    do begin
      ok = s_ready;
      @(negedge clk);
      i++;
    end while (!ok && i < 200);
    s_valid = 1'b0;
  endtask

  task automatic wait_cnt(input int target, input string nm);
    int i;
    i = 0;
    while (int'(bit_cnt) != target && i < 200) begin @(negedge clk); i++; end
    chk({nm, "_cnt_timeout"}, 64'(i < 200), 64'd1);
  endtask

  task automatic run_vec(input int k);
    int i;
    string nm;
    nm = $sformatf("v%0d", k);
    n_en = 0; got = '0; overlap = 0;
    pulse_start();
    chk({nm, "_start_done"}, 64'(done), 64'd0);
    chk({nm, "_start_cnt"}, 64'(bit_cnt), 64'd0);
    chk({nm, "_start_busy"}, 64'(busy), 64'd1);
    send_word(vecs[k].w0, vecs[k].stall, {nm, "_w0"});
    send_word(vecs[k].w1, vecs[k].stall, {nm, "_w1"});
    i = 0;
    while (!done && i < 200) begin @(negedge clk); i++; end
    chk({nm, "_done_timeout"}, 64'(i < 200), 64'd1);
    repeat (3) @(negedge clk);
    chk({nm, "_stream"}, 64'(got[39:0]), 64'(vecs[k].exp));
    chk({nm, "_en_cycles"}, 64'(n_en), 64'd40);
    chk({nm, "_bit_cnt"}, 64'(bit_cnt), 64'd40);
    chk({nm, "_done"}, 64'(done), 64'd1);
    chk({nm, "_idle_outs"}, {61'd0, busy, s_ready, cfg_en}, 64'd0);
    chk({nm, "_en_in_load"}, 64'(overlap), 64'd0);
  endtask

  task automatic rb_check(input string nm, input int exp_n);
`ifdef QLF_CFG_READBACK_EN
    chk({nm, "_rb_count"}, 64'(rb_q.size()), 64'(exp_n));
    if (exp_n == 2) begin
      chk({nm, "_rb_w0"}, 64'((rb_q.size() > 0) ? rb_q[0] : 32'hBAD0BAD0), 64'hDEADBEEF);
      chk({nm, "_rb_w1"}, 64'((rb_q.size() > 1) ? rb_q[1] : 32'hBAD0BAD0), 64'h0000005A);
    end
`else
    chk({nm, "_rb_quiet_n"}, 64'(exp_n >= 0), 64'd1);
    chk({nm, "_rb_quiet"}, 64'(rb_bad), 64'd0);
`endif
  endtask

  initial begin
    int snap;
    R = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
    cfg_din = 1'b0; pat = 40'h5A_DEADBEEF; n_en = 0; overlap = 0; rb_bad = 0;
    vecs[0] = '{32'hA5A5_0F0F, 32'h0000_00C3, 0, 40'hC3_A5A50F0F};
    vecs[1] = '{32'hA5A5_0F0F, 32'h0000_00C3, 5, 40'hC3_A5A50F0F};
    vecs[2] = '{32'hFFFF_FFFF, 32'h1234_5678, 2, 40'h78_FFFFFFFF};
    vecs[3] = '{32'h0000_0001, 32'hFFFF_FF80, 1, 40'h80_00000001};

    #3;
    chk("rst_ctrl", {58'd0, cfg_dout, cfg_en, s_ready, busy, done, rb_valid}, 64'd0);
    chk("rst_cnt", 64'(bit_cnt), 64'd0);
    chk("rst_rb_data", 64'(rb_data), 64'd0);
    @(negedge clk); R = 1'b1;

    rb_q.delete();
    for (int k = 0; k < 4; k++) run_vec(k);
    rb_check("tbl", 8);

    // abort mid-word; partial readback is dropped and the restart begins at 0
    rb_q.delete(); n_en = 0;
    pulse_start();
    send_word(32'hA5A5_0F0F, 0, "ab_w0");
    wait_cnt(17, "ab");
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("ab_outs", {60'd0, busy, s_ready, cfg_en, done}, 64'd0);
    chk("ab_cnt_kept", 64'(bit_cnt), 64'd17);
    snap = n_en;
    repeat (3) @(negedge clk);
    chk("ab_no_shift", 64'(n_en), 64'(snap));
`ifdef QLF_CFG_READBACK_EN
    chk("ab_rb_none", 64'(rb_q.size()), 64'd0);
`endif
    rb_q.delete(); rb_bad = 0;
    run_vec(0);
    rb_check("ab_restart", 2);

    // start during SHIFT is ignored, then reset lands mid-shift
    n_en = 0;
    pulse_start();
    send_word(32'hA5A5_0F0F, 0, "rs_w0");
    wait_cnt(5, "rs5");
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_start_cnt", 64'(bit_cnt), 64'd6);
    chk("busy_start_busy", 64'(busy), 64'd1);
    wait_cnt(10, "rs10");
    #2 R = 1'b0;
    #1;
    chk("rst_mid_ctrl", {58'd0, cfg_dout, cfg_en, s_ready, busy, done, rb_valid}, 64'd0);
    chk("rst_mid_cnt", 64'(bit_cnt), 64'd0);
    chk("rst_mid_rb", 64'(rb_data), 64'd0);
    snap = n_en;
    repeat (3) @(negedge clk);
    chk("rst_mid_no_shift", 64'(n_en), 64'(snap));
    R = 1'b1;

    // abort wins over a simultaneous start
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", {62'd0, busy, s_ready}, 64'd0);

    rb_q.delete(); rb_bad = 0;
    run_vec(0);
    rb_check("final", 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
